// File: rtl/serial_byte_receiver_if.sv
// rtl/serial_byte_receiver_if.sv - serial line, word handshake and status flags of the byte receiver
interface serial_byte_receiver_if #(
   parameter int WIDTH = 8
);
   logic             SerialIn;
   logic             DataReady;
   logic             ClearErr;
   logic [WIDTH-1:0] Data_OUT;
   logic             DataValid;
   logic             FrameError;
   logic             Overrun;

   // master is the receiver itself; slave is the line driver / word consumer
   modport master (
      input  SerialIn, DataReady, ClearErr,
      output Data_OUT, DataValid, FrameError, Overrun
   );

   modport slave (
      output SerialIn, DataReady, ClearErr,
      input  Data_OUT, DataValid, FrameError, Overrun
   );
endinterface

// File: rtl/serial_byte_receiver.sv
// rtl/serial_byte_receiver.sv - oversampled start/stop serial receiver with valid/ready word output
module serial_byte_receiver #(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input logic                  clock,
   input logic                  resetn,
   serial_byte_receiver_if.master bus
);
   localparam int H  = CLKS_PER_BIT / 2;
   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam int IW = $clog2(WIDTH);

   localparam logic [CW-1:0] CNT_HALF = CW'(H);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);
   localparam logic [IW-1:0] IDX_ONE  = IW'(1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] sr;
   logic             word_done;
   logic             overrun_set;

   // The stop-sample edge is the only place a word can complete.
   always_comb begin
      word_done   = (state == STOP) && (cnt == CNT_LAST) && bus.SerialIn;
      overrun_set = word_done && bus.DataValid && !bus.DataReady;
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state          <= IDLE;
         cnt            <= '0;
         idx            <= '0;
         sr             <= '0;
         bus.Data_OUT   <= '0;
         bus.DataValid  <= 1'b0;
         bus.FrameError <= 1'b0;
         bus.Overrun    <= 1'b0;
      end else begin
         bus.FrameError <= 1'b0;
         case (state)
            IDLE: begin
               if (!bus.SerialIn) begin
                  state <= START;
                  cnt   <= CNT_ONE;
               end
            end
            START: begin
               if (cnt == CNT_HALF) begin
                  cnt   <= '0;
                  idx   <= '0;
                  state <= bus.SerialIn ? IDLE : DATA;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            DATA: begin
               if (cnt == CNT_LAST) begin
                  cnt <= '0;
                  sr  <= {bus.SerialIn, sr[WIDTH-1:1]};
                  if (idx == IDX_LAST) begin
                     state <= STOP;
                  end else begin
                     idx <= idx + IDX_ONE;
                  end
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            STOP: begin
               if (cnt == CNT_LAST) begin
                  cnt   <= '0;
                  state <= IDLE;
                  if (!bus.SerialIn) begin
                     bus.FrameError <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: state <= IDLE;
         endcase

         // A consumer handshake in the completion cycle frees the slot for the new word.
         if (word_done) begin
            if (!bus.DataValid || bus.DataReady) begin
               bus.Data_OUT  <= sr;
               bus.DataValid <= 1'b1;
            end
         end else if (bus.DataValid && bus.DataReady) begin
            bus.DataValid <= 1'b0;
         end

         if (overrun_set) begin
            bus.Overrun <= 1'b1;
         end else if (bus.ClearErr) begin
            bus.Overrun <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_serial_byte_receiver.sv
// tb/tb_serial_byte_receiver.sv - randomized frame stimulus against a completion-schedule reference model
module tb_serial_byte_receiver;
   localparam int WIDTH    = 8;
   localparam int CPB      = 4;
   localparam int H        = CPB / 2;
   localparam int STOP_OFS = H + (WIDTH + 1) * CPB;

   logic clock  = 1'b0;
   logic resetn = 1'b0;

   serial_byte_receiver_if #(.WIDTH(WIDTH)) bus ();

   serial_byte_receiver #(
      .WIDTH       (WIDTH),
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clock (clock),
      .resetn(resetn),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      int               cyc;
      logic [WIDTH-1:0] word;
      bit               stop;
   } frame_t;

   frame_t           sched[$];
   int               tests_run    = 0;
   int               tests_failed = 0;
   int               cyc          = 0;
   int               ready_mode   = 0;
   int               clr_pct      = 0;
   logic [WIDTH-1:0] m_data       = '0;
   bit               m_valid      = 1'b0;
   bit               m_fe         = 1'b0;
   bit               m_ovr        = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   // Outcome of each edge is derived from the frame schedule, not from line sampling.
   task automatic model_edge(input bit rdy, input bit clr, input bit rst_n);
      frame_t f;
      bit     complete = 1'b0;
      bit     ferr     = 1'b0;
      bit     set_ovr  = 1'b0;
      if (!rst_n) begin
         m_valid = 1'b0;
         m_data  = '0;
         m_ovr   = 1'b0;
         m_fe    = 1'b0;
         sched.delete();
         return;
      end
      if (sched.size() > 0 && sched[0].cyc == cyc) begin
         f = sched.pop_front();
         if (f.stop) complete = 1'b1;
         else        ferr     = 1'b1;
      end
      if (complete) begin
         if (!m_valid || rdy) begin
            m_data  = f.word;
            m_valid = 1'b1;
         end else begin
            set_ovr = 1'b1;
         end
      end else if (m_valid && rdy) begin
         m_valid = 1'b0;
      end
      if (set_ovr)  m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
      m_fe = ferr;
   endtask

   task automatic step(input bit line, input bit rst_n = 1'b1, input bit clr_force = 1'b0);
      bit rdy;
      bit clr;
      @(negedge clock);
      rdy = (ready_mode == 1) || (ready_mode == 2 && $urandom_range(0, 1) == 1);
      clr = clr_force || ($urandom_range(0, 99) < clr_pct);
      bus.SerialIn  = line;
      bus.DataReady = rdy;
      bus.ClearErr  = clr;
      resetn        = rst_n;
      @(posedge clock);
      cyc++;
      model_edge(rdy, clr, rst_n);
      #1;
      check("valid",     32'(bus.DataValid),  32'(m_valid));
      check("data",      32'(bus.Data_OUT),   32'(m_data));
      check("frame_err", 32'(bus.FrameError), 32'(m_fe));
      check("overrun",   32'(bus.Overrun),    32'(m_ovr));
   endtask

   task automatic hold(input bit line, input int n);
      repeat (n) step(line);
   endtask

   task automatic send_frame(input logic [WIDTH-1:0] word, input bit stop);
      frame_t f;
      f.cyc  = cyc + 1 + STOP_OFS;
      f.word = word;
      f.stop = stop;
      sched.push_back(f);
      hold(1'b0, CPB);
      for (int i = 0; i < WIDTH; i++) hold(word[i], CPB);
      hold(stop, CPB);
   endtask

   task automatic glitch(input int low_len);
      hold(1'b0, low_len);
      hold(1'b1, CPB + 2);
   endtask

   initial begin
      bit prev_bad;
      bus.SerialIn  = 1'b1;
      bus.DataReady = 1'b0;
      bus.ClearErr  = 1'b0;

      repeat (3) step(1'b1, 1'b0);
      hold(1'b1, 4);

      ready_mode = 0;
      send_frame(8'hA5, 1'b1);
      hold(1'b1, 6);

      glitch(1);
      hold(1'b1, 14);

      send_frame(8'h3C, 1'b0);
      hold(1'b1, 6);

      send_frame(8'h3C, 1'b1);
      send_frame(8'hC3, 1'b1);
      hold(1'b1, 4);
      step(1'b1, 1'b1, 1'b1);
      hold(1'b1, 4);

      ready_mode = 1;
      hold(1'b1, 3);
      send_frame(8'h3C, 1'b1);
      hold(1'b1, 3);
      send_frame(8'hC3, 1'b1);
      hold(1'b1, 4);

      ready_mode = 0;
      hold(1'b1, 2);
      hold(1'b0, CPB);
      hold(1'b1, 3 * CPB);
      step(1'b1, 1'b0);
      hold(1'b1, 6);
      send_frame(8'h81, 1'b1);
      hold(1'b1, 6);

      ready_mode = 2;
      clr_pct    = 5;
      prev_bad   = 1'b0;
      for (int n = 0; n < 40; n++) begin
         logic [WIDTH-1:0] w;
         bit               st;
         w  = WIDTH'($urandom);
         st = ($urandom_range(0, 7) != 0);
         hold(1'b1, $urandom_range(0, 4) + (prev_bad ? 2 : 0));
         if ($urandom_range(0, 4) == 0) glitch($urandom_range(1, H));
         send_frame(w, st);
         prev_bad = !st;
      end
      hold(1'b1, 8);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
